// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared state encodings and widths for the sequential multiplier
//   OP_W      operand width, fixed by the shared 32-bit adder
//   LAST_ITER terminal iteration count that ends RUN
package mult_seq_pkg;
   localparam int OP_W = 32;
   localparam logic [4:0] LAST_ITER = 5'd31;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/multiplier_32_seq_if.sv
// multiplier_32_seq_if: request/result bundle of the sequential multiplier
//   start, a, b           requester -> multiplier
//   busy, done, product   multiplier -> requester
interface multiplier_32_seq_if;
   import mult_seq_pkg::*;
   logic                start;
   logic [OP_W-1:0]     a;
   logic [OP_W-1:0]     b;
   logic                busy;
   logic                done;
   logic [2*OP_W-1:0]   product;
   modport master (output start, a, b, input busy, done, product);
   modport slave (input start, a, b, output busy, done, product);
endinterface

// File: rtl/multiplier_32_seq_adder.sv
// full_adder_32: 32-bit adder with carry in/out, the multiplier's only datapath adder
//   A, B, C_I  addends and carry in
//   R, C_O     sum and carry out
module full_adder_32 (
   output logic [31:0] R,
   output logic        C_O,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        C_I
);
   assign {C_O, R} = {1'b0, A} + {1'b0, B} + {32'd0, C_I};
endmodule

// File: rtl/multiplier_32_seq.sv
// multiplier_32_seq: 32x32 unsigned shift-add multiplier, fixed 32-cycle latency
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         slave side: start/a/b in, busy/done/product out
module multiplier_32_seq
   import mult_seq_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   multiplier_32_seq_if.slave         bus
);
   state_t state, state_nxt;
   logic [4:0]        count;
   logic [OP_W-1:0]   mcand, hi, lo, sum;
   logic              carry;
   logic [2*OP_W-1:0] shifted;
   logic [2*OP_W-1:0] product;
   logic              accept;
   // a zero addend leaves {carry,sum} = {0,hi} when the multiplier bit is clear
   full_adder_32 u_add (
      .R   (sum),
      .C_O (carry),
      .A   (hi),
      .B   (lo[0] ? mcand : '0),
      .C_I (1'b0)
   );
   // carry rides in as bit 64 before the shift, so no overflow is lost
   assign shifted = {carry, sum, lo[OP_W-1:1]};
   assign accept = bus.start && state != RUN;
   always_comb begin
      state_nxt = state;
      state_nxt = state == RUN ? (count == LAST_ITER ? DONE : RUN)
                               : (bus.start ? RUN : IDLE);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         count   <= '0;
         mcand   <= '0;
         hi      <= '0;
         lo      <= '0;
         product <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            mcand <= bus.a;
            hi    <= '0;
            lo    <= bus.b;
            count <= '0;
         end else if (state == RUN) begin
            {hi, lo} <= shifted;
            count    <= count == LAST_ITER ? count : count + 5'd1;
            if (count == LAST_ITER) product <= shifted;
         end
      end
   end
   assign bus.busy    = state == RUN;
   assign bus.done    = state == DONE;
   assign bus.product = product;
endmodule

// File: doc/multiplier_32_seq.md
MULTIPLIER_32_SEQ -- requirements
Module: multiplier_32_seq

Interface
REQ-001 Parameters SHALL be none; operand width is fixed at 32 by the shared adder.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 a  input  32  multiplicand, unsigned; captured when start is accepted.
REQ-006 b  input  32  multiplier, unsigned; captured when start is accepted.
REQ-007 busy  output  1  high while in RUN.
REQ-008 done  output  1  one-cycle pulse; product valid in that cycle.
REQ-009 product  output  64  result register; holds its value until the next accepted start.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-011 Transitions SHALL be: IDLE→RUN on start; RUN→DONE when iteration count reaches 31; DONE→RUN on start; DONE→IDLE otherwise.
REQ-012 On accept: mcand←a; hi←0; lo←b; count←0.
REQ-013 Each RUN cycle: if lo[0]=1 then {c,s}=hi+mcand via full_adder_32 with C_I=0, else {c,s}={0,hi}; then {hi,lo}←{c,s,lo}>>1; count←count+1.
REQ-014 Arithmetic SHALL be unsigned; the adder carry-out SHALL be kept as bit 64 of the pre-shift value, so no overflow is lost.
REQ-015 Latency SHALL be fixed: start accepted at edge N → done=1 and product={hi,lo} in the cycle after edge N+32 (32 RUN cycles), independent of operand values.
REQ-016 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-017 start in RUN SHALL be ignored; operand changes in RUN SHALL NOT affect the result.
REQ-018 start in DONE SHALL be accepted (back-to-back); done still pulses for exactly one cycle and the new operation begins.
REQ-019 product SHALL update only on entry to DONE; it SHALL NOT expose partial sums during RUN.
REQ-020 Iteration counter SHALL be 5 bits and SHALL NOT wrap mid-operation; terminal value 31 ends RUN.

Reset
REQ-021 rst_n=0 SHALL force state=IDLE, count=0, mcand=0, hi=0, lo=0, product=0, busy=0, done=0 immediately, without a clock.
REQ-022 Reset mid-RUN SHALL abort the operation with no done pulse; the first start after deassertion SHALL behave as from power-up.
REQ-023 start coinciding with the rst_n deassertion edge SHALL NOT be accepted.

Structure
REQ-024 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the constants OP_W=32 and LAST_ITER=31 SHALL live in shared package mult_seq_pkg.
REQ-025 The block SHALL instantiate exactly one full_adder_32 (ports R, C_O, A, B, C_I) as its sole adder; no other "+" on 32-bit data is permitted.
REQ-026 The 5-bit counter SHALL be the only other arithmetic; no further sub-modules.

Verification
REQ-027 a=3, b=5, start for 1 cycle → busy for 32 cycles, done at +33, product=64'd15.
REQ-028 a=b=32'hFFFFFFFF → product=64'hFFFFFFFE00000001 (carry-out path exercised).
REQ-029 a=32'h12345678, b=0 → product=0; a=0, b=32'hFFFFFFFF → product=0; latency is still 33 in both cases.
REQ-030 Start 7×9; at cycle +10 pulse start with a=b=2 → the second start is ignored, product=64'd63.
REQ-031 Start 7×9; hold start=1 with a=4, b=6 in the DONE cycle → done pulses once with product=63, then 33 cycles later product=24.
REQ-032 Start 7×9; drop rst_n at cycle +15 for 2 cycles → outputs go to 0 immediately with no done pulse; then 2×3 → product=6.
